// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with HI/LO registers.
//   Multiply/MAC ops hold busy for MUL_LAT cycles, then write {HI,LO}.
//   Divide ops run a radix-2 restoring divider on magnitudes:
//   1 setup cycle, WIDTH iteration cycles, 1 sign fix-up cycle.
// Ports:
//   clk, reset (async, active low)
//   start, MDUOp  - issue strobe and operation, sampled on rising edge
//   ID_MDUOp      - op in decode, only used to form stall
//   A, B          - operands (latched when an op is accepted)
//   HI, LO        - architectural result registers
//   Out           - MFHI/MFLO result, combinational
//   busy, stall   - op in flight / decode must wait
module mdu_iter #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       MDUOp,
    input  logic [3:0]       ID_MDUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] Out,
    output logic             busy,
    output logic             stall
);
    localparam logic [3:0] OP_MULT  = 4'd1,  OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3,  OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5,  OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7,  OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9,  OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11, OP_MSUBU = 4'd12;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state;
    logic [3:0]         op_r;
    logic [WIDTH-1:0]   a_r, b_r;
    logic [6:0]         cnt;
    logic               div_setup;
    logic [WIDTH-1:0]   rem, quo, dvs;

    // Operand sign handling shared by multiply and divide
    logic                 sgn;
    logic [2*WIDTH-1:0]   a_ext, b_ext, prod, acc, mac;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 q_neg, r_neg;
    logic [WIDTH:0]       shifted, diff;
    logic                 ge;

    always_comb begin
        sgn   = (op_r == OP_MULT) || (op_r == OP_DIV) ||
                (op_r == OP_MADD) || (op_r == OP_MSUB);
        a_ext = sgn ? {{WIDTH{a_r[WIDTH-1]}}, a_r} : {{WIDTH{1'b0}}, a_r};
        b_ext = sgn ? {{WIDTH{b_r[WIDTH-1]}}, b_r} : {{WIDTH{1'b0}}, b_r};
        // Low 2*WIDTH bits of the extended product equal the exact product
        prod  = a_ext * b_ext;
        acc   = {HI, LO};
        if (op_r == OP_MADD || op_r == OP_MADDU)
            mac = acc + prod;
        else if (op_r == OP_MSUB || op_r == OP_MSUBU)
            mac = acc - prod;
        else
            mac = prod;

        a_mag = (sgn && a_r[WIDTH-1]) ? -a_r : a_r;
        b_mag = (sgn && b_r[WIDTH-1]) ? -b_r : b_r;
        // Quotient negative when signs differ; remainder follows dividend.
        // Most-negative / -1 falls out naturally: magnitude 2^(WIDTH-1),
        // no negation, which reads back as the most-negative value.
        q_neg = sgn && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
        r_neg = sgn && a_r[WIDTH-1];

        shifted = {rem, quo[WIDTH-1]};
        ge      = shifted >= {1'b0, dvs};
        diff    = shifted - {1'b0, dvs};
    end

    always_comb begin
        Out = '0;
        if (start && !busy) begin
            if (MDUOp == OP_MFHI)      Out = HI;
            else if (MDUOp == OP_MFLO) Out = LO;
        end
    end

    assign stall = busy && (ID_MDUOp != 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            HI        <= '0;
            LO        <= '0;
            busy      <= 1'b0;
            op_r      <= '0;
            a_r       <= '0;
            b_r       <= '0;
            cnt       <= '0;
            div_setup <= 1'b0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (MDUOp)
                            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
                            OP_MSUB, OP_MSUBU: begin
                                op_r  <= MDUOp;
                                a_r   <= A;
                                b_r   <= B;
                                cnt   <= 7'(MUL_LAT - 1);
                                busy  <= 1'b1;
                                state <= S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_r      <= MDUOp;
                                a_r       <= A;
                                b_r       <= B;
                                div_setup <= 1'b1;
                                busy      <= 1'b1;
                                state     <= S_DIV;
                            end
                            OP_MTHI: HI <= A;
                            OP_MTLO: LO <= A;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (cnt == '0) begin
                        {HI, LO} <= mac;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt - 7'd1;
                    end
                end
                S_DIV: begin
                    if (div_setup) begin
                        div_setup <= 1'b0;
                        if (b_r == '0) begin
                            // Divide by zero: abandon, HI/LO untouched
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            rem <= '0;
                            quo <= a_mag;
                            dvs <= b_mag;
                            cnt <= 7'(WIDTH - 1);
                        end
                    end else begin
                        // quo doubles as the dividend shift register
                        rem <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], ge};
                        if (cnt == '0) state <= S_DONE;
                        else           cnt   <= cnt - 7'd1;
                    end
                end
                S_DONE: begin
                    HI    <= r_neg ? -rem : rem;
                    LO    <= q_neg ? -quo : quo;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  MDUOp = 4'd0, ID_MDUOp = 4'd0;
    logic [31:0] A = '0, B = '0;
    logic [31:0] HI, LO, Out;
    logic        busy, stall;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        int          id;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    mdu_iter #(.WIDTH(32), .MUL_LAT(5)) dut (
        .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp),
        .ID_MDUOp(ID_MDUOp), .A(A), .B(B), .HI(HI), .LO(LO), .Out(Out),
        .busy(busy), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: a busy falling edge marks a completed op; compare against
    // the oldest expectation, including how long busy was held.
    int  bcnt = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            bcnt = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy) bcnt++;
            if (prev_busy && !busy) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_completion", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk($sformatf("op%0d_HI", e.id), {32'd0, HI}, {32'd0, e.hi});
                    chk($sformatf("op%0d_LO", e.id), {32'd0, LO}, {32'd0, e.lo});
                    chk($sformatf("op%0d_busy_cycles", e.id), 64'(bcnt), 64'(e.cyc));
                end
                bcnt = 0;
            end
            prev_busy = busy;
        end
    end

    // Drive one op so it is sampled on the next rising edge, then scramble
    // the operands to show they were latched.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; MDUOp = op; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; MDUOp = 4'd0; A = $urandom; B = $urandom;
    endtask

    // Returns on the first falling edge that sees busy low.
    task automatic wait_done(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk({name, "_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic run(input int id, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi,
                       input logic [31:0] elo, input int cyc);
        exp_t e;
        e.id = id; e.hi = ehi; e.lo = elo; e.cyc = cyc;
        sbq.push_back(e);
        issue(op, a, b);
        wait_done($sformatf("op%0d", id));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        #12;
        chk("reset_HI", {32'd0, HI}, 64'd0);
        chk("reset_LO", {32'd0, LO}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Multiply, signed and unsigned
        run(1, 4'd1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 5);
        run(2, 4'd2, 32'hFFFFFFFD, 32'd7, 32'h00000006, 32'hFFFFFFEB, 5);
        // Divide
        run(3, 4'd4, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 34);
        run(4, 4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34);
        run(5, 4'd3, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34);

        // MTHI/MTLO then MAC chain
        issue(4'd7, 32'd0, 32'd0);
        wait_done("mthi");
        chk("mthi_busy", {63'd0, busy}, 64'd0);
        chk("mthi_HI", {32'd0, HI}, 64'd0);
        issue(4'd8, 32'h0A, 32'd0);
        wait_done("mtlo");
        chk("mtlo_LO", {32'd0, LO}, 64'h0A);
        run(6, 4'd9,  32'd3,  32'd4, 32'h00000000, 32'h00000016, 5);
        run(7, 4'd12, 32'h20, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFF6, 5);

        // Move-from while idle
        start = 1'b1; MDUOp = 4'd5; #1;
        chk("mfhi_out", {32'd0, Out}, {32'd0, 32'hFFFFFFFF});
        MDUOp = 4'd6; #1;
        chk("mflo_out", {32'd0, Out}, {32'd0, 32'hFFFFFFF6});
        start = 1'b0; #1;
        chk("mf_nostart_out", {32'd0, Out}, 64'd0);

        // Back-to-back signed/unsigned MAC on the just-written HI/LO
        run(8,  4'd9,  32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5);
        run(9,  4'd10, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFEF, 5);
        run(10, 4'd11, 32'd2,        32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFF1, 5);

        // Divide by zero leaves HI/LO; overflow case
        issue(4'd7, 32'h11, 32'd0); wait_done("mthi2");
        issue(4'd8, 32'h22, 32'd0); wait_done("mtlo2");
        run(11, 4'd3, 32'd5, 32'd0, 32'h00000011, 32'h00000022, 1);
        run(12, 4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34);

        // Activity while busy: stall, Out gating, ignored start
        begin
            exp_t e;
            e.id = 13; e.hi = 32'd0; e.lo = 32'd42; e.cyc = 5;
            sbq.push_back(e);
        end
        ID_MDUOp = 4'd3;
        issue(4'd1, 32'd6, 32'd7);
        chk("stall_on", {63'd0, stall}, 64'd1);
        ID_MDUOp = 4'd0; #1;
        chk("stall_no_id_op", {63'd0, stall}, 64'd0);
        ID_MDUOp = 4'd5;
        start = 1'b1; MDUOp = 4'd5; #1;
        chk("mfhi_busy_out", {32'd0, Out}, 64'd0);
        chk("stall_mf_busy", {63'd0, stall}, 64'd1);
        MDUOp = 4'd4; A = 32'd1; B = 32'd1;
        @(posedge clk); #1;
        start = 1'b0; MDUOp = 4'd0;
        wait_done("op13");
        chk("stall_off", {63'd0, stall}, 64'd0);
        ID_MDUOp = 4'd0;
        // The ignored DIVU must not have started afterwards
        @(negedge clk);
        chk("ignored_start_busy", {63'd0, busy}, 64'd0);

        // Reset mid-divide, then a fresh op right after release
        issue(4'd4, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_HI", {32'd0, HI}, 64'd0);
        chk("abort_LO", {32'd0, LO}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        #1 reset = 1'b1;
        run(14, 4'd1, 32'd3, 32'd5, 32'h00000000, 32'h0000000F, 5);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameter WIDTH, default 32, operand/HI/LO/Out width; legal values 8..64, even.
REQ-002 Parameter MUL_LAT, default 5, multiply/MAC busy cycles; legal values 1..16.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous active-low reset; 0 clears all state immediately.
REQ-005 start  input  1  issue strobe for MDUOp; sampled on the rising edge.
REQ-006 MDUOp  input  4  operation issued this cycle.
REQ-007 ID_MDUOp  input  4  op of the instruction currently in decode; used for stall only.
REQ-008 A  input  WIDTH  operand rs.
REQ-009 B  input  WIDTH  operand rt.
REQ-010 HI  output  WIDTH  HI register (registered).
REQ-011 LO  output  WIDTH  LO register (registered).
REQ-012 Out  output  WIDTH  move-from result (combinational).
REQ-013 busy  output  1  operation in flight (registered).
REQ-014 stall  output  1  busy && (ID_MDUOp != 0), combinational.

Function
REQ-015 MDUOp encoding: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU; 0 and 13-15 are NOP.
REQ-016 FSM states IDLE, MUL, DIV, DONE; start is accepted only in IDLE with busy=0; start while busy is ignored, no state change.
REQ-017 Operands are latched at the accepting edge; A/B may change afterwards without effect.
REQ-018 MULT/MULTU/MADD*/MSUB*: IDLE->MUL, busy=1 for exactly MUL_LAT cycles, then {HI,LO} written on the edge busy falls, FSM returns to IDLE.
REQ-019 MULT/MULTU: {HI,LO} = 2*WIDTH-bit signed/unsigned product.
REQ-020 MADD/MADDU: {HI,LO} += product; MSUB/MSUBU: {HI,LO} -= product; 2*WIDTH-bit modulo arithmetic, accumulator is {HI,LO} at completion time.
REQ-021 DIV/DIVU: IDLE->DIV, radix-2 restoring shift-subtract on magnitudes, one quotient bit per cycle; busy=1 for WIDTH+2 cycles (1 setup, WIDTH iterations, 1 sign fix-up) -> DONE writes HI/LO -> IDLE.
REQ-022 Signed divide: quotient truncates toward zero, LO=quotient, HI=remainder with sign of dividend.
REQ-023 Signed overflow (A = most-negative, B = -1): LO = most-negative, HI = 0, no exception.
REQ-024 Divide by zero (B=0): no iteration; busy=1 for exactly 1 cycle; HI/LO unchanged.
REQ-025 MTHI/MTLO: HI<=A / LO<=A on the accepting edge; busy stays 0.
REQ-026 MFHI/MFLO: Out = HI / LO while start=1, busy=0 and MDUOp=5/6; Out = 0 in all other cases, including start=1 with busy=1.
REQ-027 HI/LO never change during busy; intermediate values are held in internal registers only.
REQ-028 Back-to-back: a new start is accepted on the first edge with busy=0 and uses the just-written HI/LO.
REQ-029 stall asserts in the cycle busy rises if ID_MDUOp != 0, and deasserts the cycle busy falls.

Reset
REQ-030 reset=0 forces HI=0, LO=0, busy=0, FSM=IDLE and clears internal counters and operand/partial registers asynchronously, including mid-operation; the aborted result is discarded.
REQ-031 The first start is accepted on the first rising edge after reset returns to 1.

Verification (WIDTH=32, MUL_LAT=5)
REQ-032 MULT A=0xFFFFFFFD, B=7 -> busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-033 DIVU A=100, B=7 -> busy for 34 cycles, then LO=0x0000000E, HI=0x00000002; DIV A=0xFFFFFFF9, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-034 MTHI 0, MTLO 0x0A, MADD A=3, B=4 -> LO=0x16, HI=0; MSUBU A=0x20, B=1 -> {HI,LO}=0xFFFFFFFF_FFFFFFF6.
REQ-035 DIV A=5, B=0 with HI=0x11, LO=0x22 -> busy for 1 cycle, HI=0x11, LO=0x22 unchanged; DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-036 Start DIVU, pulse reset low at cycle 10 -> HI=LO=0 and busy=0 immediately; a MULT issued after release completes normally.
REQ-037 MFHI with start=1 while busy=1 -> Out=0, stall=1 when ID_MDUOp!=0; a second start during busy is ignored and the final HI/LO equal the first operation's result.
